// File: rtl/demux1to4_stream.sv
// demux1to4_stream: registered 1-to-4 valid/ready stream demultiplexer.
// Each channel is a one-entry holding slot with an 8-bit transfer counter.
// The select travels with the word; only the selected slot gates in_ready.

// One output channel: holding register, valid flag and drain counter.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [7:0]       count
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       count_q, count_d;
    logic             xfer;

    // Load wins over drain so a full slot can be emptied and refilled on one edge.
    always_comb begin
        xfer    = valid_q & drain_rdy;
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q + {7'd0, xfer};
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // Slot state; reset discards any buffered word and zeroes the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= 8'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign count = count_q;
endmodule

// Top: steers each accepted word into the slot named by in_sel.
module demux1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [31:0]        out_count
);
    logic [3:0] load;

    // Ready looks only at the selected slot: it can take a word if empty or draining now.
    always_comb begin
        in_ready = !out_valid[in_sel] | out_ready[in_sel];
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        assign load[k] = in_valid & in_ready & (in_sel == 2'(k));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .drain_rdy (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH]),
            .count     (out_count[k*8 +: 8])
        );
    end
endmodule
